// File: rtl/dac_write_sched.sv
// Shadow-register write scheduler and 16-bit serializer for the Flashy ADC-board control DAC.
// Dirty registers are sent round-robin; reset marks every register dirty so defaults go out first.
module dac_write_sched #(
  parameter int unsigned BIT_CYCLES = 256,
  parameter int unsigned GAP_CYCLES = 32,
  parameter bit          REFRESH    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       frame_done,
  output logic       ADC_DACCTRL
);

  localparam int unsigned BW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    shadow [4];
  logic [3:0]    dirty;
  logic [1:0]    ptr;
  logic [1:0]    sel;
  logic [1:0]    idx;
  logic [15:0]   shreg;
  logic [BW-1:0] cyc_cnt;
  logic [3:0]    bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic          bit_end;
  logic          frame_end;
  logic          gap_end;
  logic          wr_fire;

  assign bit_end   = (cyc_cnt == BIT_LAST);
  assign frame_end = bit_end && (bit_cnt == 4'd15);
  assign gap_end   = (gap_cnt == GAP_LAST);
  assign wr_ready  = !rst && (state != LOAD);
  assign wr_fire   = wr_valid && wr_ready;
  assign busy      = (state != IDLE);

  // First dirty index at or above ptr (wrapping); the lowest offset is assigned last and wins.
  always_comb begin
    sel = ptr;
    idx = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      idx = ptr + 2'(i - 1);
      if (dirty[idx]) sel = idx;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if ((|dirty) || REFRESH) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (frame_end) state_nxt = GAP;
      GAP:     if (gap_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow[0]   <= 8'hC0;
      shadow[1]   <= 8'h80;
      shadow[2]   <= 8'hC0;
      shadow[3]   <= 8'h80;
      dirty       <= '1;
      ptr         <= '0;
      shreg       <= '0;
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      frame_done  <= 1'b0;
      ADC_DACCTRL <= 1'b0;
    end else begin
      frame_done  <= (state == SHIFT) && frame_end;
      ADC_DACCTRL <= (state == SHIFT) ? shreg[15] : 1'b0;
      case (state)
        LOAD: begin
          shreg      <= {5'b11111, sel, 1'b1, shadow[sel]};
          dirty[sel] <= 1'b0;
          ptr        <= sel + 2'd1;
          cyc_cnt    <= '0;
          bit_cnt    <= '0;
        end
        SHIFT: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            shreg   <= {shreg[14:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
          end else begin
            cyc_cnt <= cyc_cnt + BW'(1);
          end
        end
        GAP:     gap_cnt <= gap_end ? '0 : gap_cnt + GW'(1);
        default: ;
      endcase
      // A write never lands in LOAD, so it cannot collide with the dirty clear above.
      if (wr_fire) begin
        shadow[wr_addr] <= wr_data;
        dirty[wr_addr]  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dac_write_sched.sv
// Scoreboard bench: stimulus pushes predicted frames, line monitors decode the serial output and compare.
module tb_dac_write_sched;

  localparam int B    = 4;
  localparam int G    = 2;
  localparam int FLEN = 16 * B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst0 = 1'b1, wv0 = 1'b0, rdy0, busy0, fd0, line0;
  logic [1:0] wa0 = '0;
  logic [7:0] wd0 = '0;
  logic       rst1 = 1'b1, wv1 = 1'b0, rdy1, busy1, fd1, line1;
  logic [1:0] wa1 = '0;
  logic [7:0] wd1 = '0;

  dac_write_sched #(.BIT_CYCLES(B), .GAP_CYCLES(G), .REFRESH(1'b0)) dut0 (
    .clk(clk), .rst(rst0), .wr_valid(wv0), .wr_ready(rdy0), .wr_addr(wa0), .wr_data(wd0),
    .busy(busy0), .frame_done(fd0), .ADC_DACCTRL(line0));

  dac_write_sched #(.BIT_CYCLES(B), .GAP_CYCLES(G), .REFRESH(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .wr_valid(wv1), .wr_ready(rdy1), .wr_addr(wa1), .wr_data(wd1),
    .busy(busy1), .frame_done(fd1), .ADC_DACCTRL(line1));

  int checks = 0;
  int fails  = 0;
  int nstarts [2] = '{0, 0};
  int rise_cyc[2] = '{0, 0};
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s: event did not occur within bound at cycle %0d", name, cyc);
  endtask

  // Reference model: shadow values, pending set and round-robin pointer.
  logic [7:0] m_reg[4];
  bit         m_dirty[4];
  int         m_ptr;

  function automatic void model_reset();
    m_reg[0] = 8'hC0; m_reg[1] = 8'h80; m_reg[2] = 8'hC0; m_reg[3] = 8'h80;
    for (int k = 0; k < 4; k++) m_dirty[k] = 1'b1;
    m_ptr = 0;
  endfunction

  function automatic void model_write(input int a, input logic [7:0] d);
    m_reg[a]   = d;
    m_dirty[a] = 1'b1;
  endfunction

  function automatic void model_drain();
    int sel;
    for (int iter = 0; iter < 4; iter++) begin
      sel = -1;
      for (int k = 0; k < 4; k++)
        if (sel < 0 && m_dirty[(m_ptr + k) % 4]) sel = (m_ptr + k) % 4;
      if (sel >= 0) begin
        exp_q0.push_back({5'b11111, 2'(sel), 1'b1, m_reg[sel]});
        m_dirty[sel] = 1'b0;
        m_ptr = (sel + 1) % 4;
      end
    end
  endfunction

  task automatic monitor(input int id);
    logic [15:0] sh;
    logic [15:0] exp;
    int n;
    bit inframe, stable, prev, chk_low;
    logic ln;
    inframe = 0; stable = 1; prev = 0; chk_low = 0; n = 0; sh = '0;
    forever begin
      @(negedge clk);
      ln = (id == 0) ? line0 : line1;
      if ((id == 0) ? rst0 : rst1) begin
        inframe = 0; chk_low = 0; prev = 0;
      end else begin
        if (chk_low) begin
          check($sformatf("line_low_after_frame%0d", id), 32'(ln), 32'd0);
          chk_low = 0;
        end
        if (!inframe && ln && !prev) begin
          inframe = 1; n = 0; stable = 1; sh = '0;
          nstarts[id]++;
          rise_cyc[id] = cyc;
        end
        if (inframe) begin
          if (n % B == 0) sh = {sh[14:0], ln};
          else if (ln !== sh[0]) stable = 0;
          if (n == FLEN - 1) begin
            check($sformatf("frame_done%0d", id), 32'((id == 0) ? fd0 : fd1), 32'd1);
            check($sformatf("bit_stable%0d", id), 32'(stable), 32'd1);
            if (((id == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
              checks++; fails++;
              $display("FAIL unexpected_frame%0d: got 0x%04h expected no frame at cycle %0d", id, sh, cyc);
            end else begin
              exp = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              check($sformatf("frame%0d", id), 32'(sh), 32'(exp));
            end
            inframe = 0;
            chk_low = 1;
          end
          n++;
        end
        prev = ln;
      end
    end
  endtask

  initial fork
    monitor(0);
    monitor(1);
  join_none

  task automatic do_write(input int a, input logic [7:0] d, output int acc);
    int t;
    t = 0;
    acc = -1;
    @(negedge clk);
    wv0 = 1'b1; wa0 = 2'(a); wd0 = d;
    #1;
    while (!rdy0 && t < 20) begin @(negedge clk); #1; t++; end
    if (!rdy0) begin
      fail_now("write_accept");
      wv0 = 1'b0;
    end else begin
      acc = cyc;
      @(posedge clk);
      #1 wv0 = 1'b0;
      model_write(a, d);
    end
  endtask

  task automatic wait_starts(input int id, input int target);
    int t;
    t = 0;
    while (nstarts[id] < target && t < 1000) begin @(negedge clk); t++; end
    if (nstarts[id] < target) fail_now($sformatf("frame_start%0d", id));
  endtask

  task automatic wait_drain0();
    int t;
    t = 0;
    while ((exp_q0.size() != 0 || busy0) && t < 3000) begin @(negedge clk); t++; end
    if (exp_q0.size() != 0 || busy0) fail_now("drain0");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, c0, n, prev_rise, nw, a;
    logic [7:0] d;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_line", 32'(line0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_frame_done", 32'(fd0), 32'd0);
    check("rst_wr_ready", 32'(rdy0), 32'd0);

    // Reset push
    model_reset();
    model_drain();
    @(negedge clk);
    rst0 = 1'b0;
    c0 = cyc;
    #1;
    check("cycle0_wr_ready", 32'(rdy0), 32'd1);
    check("cycle0_busy", 32'(busy0), 32'd0);
    wait_starts(0, 1);
    check("first_frame_start", 32'(rise_cyc[0] - c0), 32'd3);
    prev_rise = rise_cyc[0];
    for (int f = 2; f <= 4; f++) begin
      wait_starts(0, f);
      check("frame_period", 32'(rise_cyc[0] - prev_rise), 32'(16 * B + G + 2));
      prev_rise = rise_cyc[0];
    end
    wait_drain0();
    n = nstarts[0];
    repeat (100) @(negedge clk);
    check("idle_no_frames", 32'(nstarts[0]), 32'(n));
    check("idle_busy", 32'(busy0), 32'd0);
    check("idle_line", 32'(line0), 32'd0);

    // Single write latency
    n = nstarts[0];
    do_write(2, 8'h55, acc);
    model_drain();
    wait_starts(0, n + 1);
    check("write_to_line_latency", 32'(rise_cyc[0] - acc), 32'd4);
    wait_drain0();

    // Coalescing during a frame to addr 0
    n = nstarts[0];
    do_write(0, 8'hA7, acc);
    model_drain();
    wait_starts(0, n + 1);
    repeat (5) @(negedge clk);
    do_write(1, 8'h11, acc);
    do_write(1, 8'h22, acc);
    model_drain();
    wait_drain0();

    // Round robin from the pointer after addr 1
    n = nstarts[0];
    do_write(1, 8'h5A, acc);
    model_drain();
    wait_starts(0, n + 1);
    repeat (7) @(negedge clk);
    do_write(0, 8'($urandom), acc);
    do_write(1, 8'($urandom), acc);
    do_write(3, 8'($urandom), acc);
    model_drain();
    wait_drain0();

    // Rewrite of the register in flight
    n = nstarts[0];
    do_write(0, 8'h12, acc);
    model_drain();
    wait_starts(0, n + 1);
    repeat (3) @(negedge clk);
    do_write(0, 8'h34, acc);
    model_drain();
    wait_drain0();

    // Randomized traffic: one idle write, then up to three writes while it is on the line
    for (int it = 0; it < 20; it++) begin
      n = nstarts[0];
      do_write(int'($urandom_range(0, 3)), 8'($urandom), acc);
      model_drain();
      wait_starts(0, n + 1);
      repeat ($urandom_range(0, 40)) @(negedge clk);
      nw = int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++) begin
        a = int'($urandom_range(0, 3));
        d = 8'($urandom);
        do_write(a, d, acc);
      end
      model_drain();
      wait_drain0();
    end

    // REFRESH instance: continuous cycling, then reset in the middle of bit 7
    exp_q1.push_back(16'hF9C0); exp_q1.push_back(16'hFB80); exp_q1.push_back(16'hFDC0);
    exp_q1.push_back(16'hFF80); exp_q1.push_back(16'hF9C0);
    @(negedge clk);
    rst1 = 1'b0;
    c0 = cyc;
    wait_starts(1, 1);
    check("refresh_first_start", 32'(rise_cyc[1] - c0), 32'd3);
    wait_starts(1, 6);
    repeat (29) @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    check("line_after_midframe_rst", 32'(line1), 32'd0);
    check("refresh_frames_done", 32'(exp_q1.size()), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    repeat (2) @(negedge clk);
    exp_q1.push_back(16'hF9C0); exp_q1.push_back(16'hFB80);
    exp_q1.push_back(16'hFDC0); exp_q1.push_back(16'hFF80);
    n = nstarts[1];
    rst1 = 1'b0;
    c0 = cyc;
    wait_starts(1, n + 1);
    check("restart_first_start", 32'(rise_cyc[1] - c0), 32'd3);
    begin
      int t;
      t = 0;
      while (exp_q1.size() != 0 && t < 1000) begin @(negedge clk); t++; end
      if (exp_q1.size() != 0) fail_now("drain1");
    end
    @(negedge clk);
    rst1 = 1'b1;

    repeat (5) @(negedge clk);
    check("queue0_empty", 32'(exp_q0.size()), 32'd0);
    check("queue1_empty", 32'(exp_q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
